// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcodes, state encodings and control-field codes for the multicycle MIPS controller.
// IMM_LOGIC_EN enables andi/ori decoding as zero-extended logic immediates.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

`ifdef IMM_LOGIC_EN
    localparam bit LOGIC_EN = 1'b1;
`else
    localparam bit LOGIC_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC     = 4'd7,
        S_RWB      = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_IMM_EXEC = 4'd11,
        S_IMM_WB   = 4'd12,
        S_ILLEGAL  = 4'd15
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OPC   = 2'b11;

    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       ext_zero;
    } ctrl_t;

    function automatic logic is_logic_imm(input logic [5:0] op);
        return LOGIC_EN && (op == OP_ANDI || op == OP_ORI);
    endfunction

endpackage

// File: rtl/mc_ctrl_out_decode.sv
// mc_ctrl_out_decode: Moore decode of controller state (plus latched opcode) into the datapath control vector.
// With IMM_LOGIC_EN, andi/ori drive alu_op=11 and zero-extension.
module mc_ctrl_out_decode
    import mc_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_op,
    output ctrl_t       o_ctrl
);

    logic w_zx;

`ifdef IMM_LOGIC_EN
    assign w_zx = is_logic_imm(i_op);
`else
    assign w_zx = 1'b0;
`endif

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.ir_write  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_ALU;
            end
            S_DECODE: o_ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_RWB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALU_SUB;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCS_ALUOUT;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCS_JUMP;
            end
            S_IMM_EXEC: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = is_logic_imm(i_op) ? ALU_OPC : ALU_ADD;
                o_ctrl.ext_zero  = w_zx;
            end
            S_IMM_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.ext_zero  = w_zx;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// unidade_controle_multiciclo: multicycle MIPS control FSM holding state, latched opcode and sticky illegal flag.
// Define IMM_LOGIC_EN to accept andi/ori as zero-extended logic immediates.
module unidade_controle_multiciclo
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int STATE_W  = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                ext_zero,
    output logic                illegal,
    output logic [STATE_W-1:0]  state
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op_q;
    logic       r_illegal;
    logic [5:0] w_opcode;
    ctrl_t      w_ctrl;

    assign w_opcode = 6'(opcode);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RST:      w_next = S_FETCH;
            S_FETCH:    w_next = S_DECODE;
            S_DECODE:   w_next = (w_opcode == OP_LW || w_opcode == OP_SW) ? S_MEMADDR :
                                 (w_opcode == OP_RTYPE) ? S_EXEC :
                                 (w_opcode == OP_BEQ)   ? S_BRANCH :
                                 (w_opcode == OP_J)     ? S_JUMP :
                                 (w_opcode == OP_ADDI || is_logic_imm(w_opcode)) ? S_IMM_EXEC :
                                 S_ILLEGAL;
            S_MEMADDR:  w_next = (r_op_q == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXEC:     w_next = S_RWB;
            S_IMM_EXEC: w_next = S_IMM_WB;
            S_MEMWB, S_MEMWRITE, S_RWB, S_BRANCH, S_JUMP, S_IMM_WB: w_next = S_FETCH;
            default:    w_next = S_ILLEGAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_RST;
            r_op_q    <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            if (r_state == S_DECODE) r_op_q <= w_opcode;
            r_illegal <= r_illegal | (w_next == S_ILLEGAL);
        end
    end

    mc_ctrl_out_decode u_dec (
        .i_state (r_state),
        .i_op    (r_op_q),
        .o_ctrl  (w_ctrl)
    );

    // zero only matters where pc_write_cond is set, i.e. in BRANCH
    assign pc_en      = w_ctrl.pc_write | (w_ctrl.pc_write_cond & zero);
    assign iord       = w_ctrl.iord;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_write  = w_ctrl.mem_write;
    assign ir_write   = w_ctrl.ir_write;
    assign reg_dst    = w_ctrl.reg_dst;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign reg_write  = w_ctrl.reg_write;
    assign alu_src_a  = w_ctrl.alu_src_a;
    assign alu_src_b  = w_ctrl.alu_src_b;
    assign alu_op     = w_ctrl.alu_op;
    assign pc_source  = w_ctrl.pc_source;
    assign ext_zero   = w_ctrl.ext_zero;
    assign illegal    = r_illegal;
    assign state      = STATE_W'(r_state);

endmodule
